mdu_ctrl: RTL and testbench

//  Multi-cycle multiply/divide sequencer beside the E-stage ALU. Owns the HI/LO register pair.

---
 rtl/mdu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair; busy models the unit latency.
// Optional MDU_DIV0_FAST_EN: divide by zero finishes after a single busy cycle past issue.
//
// state | meaning
// IDLE  | no op in flight, mt/mult/div may issue
// MUL   | mult/multu counting down to commit
// DIV   | div/divu counting down to commit (or discard on divisor 0)
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        flush,
    input  logic        readSel,
    output logic [31:0] rdData,
    output logic        busy,
    output logic        done
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

`ifdef MDU_DIV0_FAST_EN
    localparam logic DIV0_FAST = 1'b1;
`else
    localparam logic DIV0_FAST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state, nextState;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      aR, bR, hiR, loR;
    logic [3:0]       opR;
    logic             doneR;

    logic isMult, isDiv, issueOk, loadMul, loadDiv, mtHi, mtLo, commit;

    assign isMult  = (op == OP_MULT) || (op == OP_MULTU);
    assign isDiv   = (op == OP_DIV)  || (op == OP_DIVU);
    assign issueOk = start && !flush && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && isMult)     nextState = MUL;
                    else if (start && isDiv) nextState = DIV;
                end
                MUL, DIV: if (cnt == CNT_W'(1)) nextState = IDLE;
                default:  nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (issueOk && (isMult || isDiv)) || (state != IDLE);
        commit  = !flush && (state != IDLE) && (cnt == CNT_W'(1));
        loadMul = issueOk && isMult;
        loadDiv = issueOk && isDiv;
        mtHi    = issueOk && (op == OP_MTHI);
        mtLo    = issueOk && (op == OP_MTLO);
    end

    // Signed divide runs on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 rem 0 naturally.
    logic        divSigned, negQ, negR;
    logic [31:0] dA, dB, uq, ur, divQ, divR;
    logic [63:0] prodU, prodS;

    always_comb begin
        divSigned = (opR == OP_DIV);
        negQ      = divSigned && (aR[31] ^ bR[31]);
        negR      = divSigned && aR[31];
        dA        = (divSigned && aR[31]) ? -aR : aR;
        dB        = (divSigned && bR[31]) ? -bR : bR;
        uq        = dA / dB;
        ur        = dA % dB;
        divQ      = negQ ? -uq : uq;
        divR      = negR ? -ur : ur;
        prodU     = {32'b0, aR} * {32'b0, bR};
        prodS     = $signed({{32{aR[31]}}, aR}) * $signed({{32{bR[31]}}, bR});
    end

    logic [31:0] resHi, resLo;
    logic        resWrite;

    always_comb begin
        resHi    = '0;
        resLo    = '0;
        resWrite = 1'b0;
        case (opR)
            OP_MULT: begin
                {resHi, resLo} = prodS;
                resWrite       = 1'b1;
            end
            OP_MULTU: begin
                {resHi, resLo} = prodU;
                resWrite       = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                resHi    = divR;
                resLo    = divQ;
                resWrite = (bR != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            aR    <= '0;
            bR    <= '0;
            opR   <= '0;
            hiR   <= '0;
            loR   <= '0;
            doneR <= 1'b0;
        end else begin
            doneR <= commit;
            if (flush) begin
                cnt <= '0;
            end else if (loadMul || loadDiv) begin
                aR  <= inA;
                bR  <= inB;
                opR <= op;
                if (loadMul)                         cnt <= CNT_W'(MULT_CYCLES);
                else if (DIV0_FAST && inB == 32'd0)  cnt <= CNT_W'(1);
                else                                 cnt <= CNT_W'(DIV_CYCLES);
            end else if (state != IDLE) begin
                cnt <= cnt - 1'b1;
            end
            if (mtHi) hiR <= inA;
            if (mtLo) loR <= inA;
            if (commit && resWrite) begin
                hiR <= resHi;
                loR <= resLo;
            end
        end
    end

    assign done   = doneR;
    assign rdData = readSel ? hiR : loR;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand sequences for flush/reset/
// start-while-busy, and randomized ops checked against an arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, flush, readSel;
    logic [3:0]  op;
    logic [31:0] inA, inB, rdData;
    logic        busy, done;

    int nCmp  = 0;
    int nFail = 0;

    logic [31:0] hiM = '0;
    logic [31:0] loM = '0;

`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_BUSY = 2;
`else
    localparam int DIV0_BUSY = 11;
`endif

    mdu_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .inA     (inA),
        .inB     (inB),
        .flush   (flush),
        .readSel (readSel),
        .rdData  (rdData),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expBusy;
        int          expDone;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: applies an op's architectural effect to hiM/loM, returns expected busy/done counts.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int eb, output int ed);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eb = 0;
        ed = 0;
        case (o)
            4'd1: begin p = 64'(sa * sb); hiM = p[63:32]; loM = p[31:0]; eb = 6; ed = 1; end
            4'd2: begin p = {32'b0, a} * {32'b0, b}; hiM = p[63:32]; loM = p[31:0]; eb = 6; ed = 1; end
            4'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    loM = q[31:0];
                    hiM = r[31:0];
                end
                eb = (b == 0) ? DIV0_BUSY : 11;
                ed = 1;
            end
            4'd4: begin
                if (b != 0) begin
                    loM = a / b;
                    hiM = a % b;
                end
                eb = (b == 0) ? DIV0_BUSY : 11;
                ed = 1;
            end
            4'd5: hiM = a;
            4'd6: loM = a;
            default: ;
        endcase
    endtask

    task automatic runOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int bc, output int dc, output int dIdx, output int lastB);
        bc = 0; dc = 0; dIdx = -1; lastB = -1;
        start = 1'b1; op = o; inA = a; inB = b;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (busy) begin bc++; lastB = i; end
            if (done) begin dc++; dIdx = i; end
            step();
            start = 1'b0; op = 4'd0;
        end
    endtask

    task automatic checkRegs(input string tag);
        readSel = 1'b0; #1;
        check({tag, "_lo"}, {32'b0, rdData}, {32'b0, loM});
        readSel = 1'b1; #1;
        check({tag, "_hi"}, {32'b0, rdData}, {32'b0, hiM});
    endtask

    vec_t vecs[12];

    initial begin
        int bc, dc, dIdx, lastB, eb, ed, cnt;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 6,  1};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 6,  1};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 11, 1};
        vecs[3]  = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        11, 1};
        vecs[4]  = '{4'd5, 32'h1234,     32'd0,        32'h1234,     32'd3,        0,  0};
        vecs[5]  = '{4'd6, 32'h5678,     32'd0,        32'h1234,     32'h5678,     0,  0};
        vecs[6]  = '{4'd3, 32'd5,        32'd0,        32'h1234,     32'h5678,     DIV0_BUSY, 1};
        vecs[7]  = '{4'd4, 32'd5,        32'd0,        32'h1234,     32'h5678,     DIV0_BUSY, 1};
        vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 11, 1};
        vecs[9]  = '{4'd7, 32'd9,        32'd9,        32'd0,        32'h80000000, 0,  0};
        vecs[10] = '{4'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 6,  1};
        vecs[11] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 11, 1};

        reset = 1'b0; start = 1'b0; flush = 1'b0; readSel = 1'b0;
        op = 4'd0; inA = '0; inB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        checkRegs("rst");
        reset = 1'b1;
        step();

        foreach (vecs[k]) begin
            runOp(vecs[k].op, vecs[k].a, vecs[k].b, bc, dc, dIdx, lastB);
            check($sformatf("vec%0d_busy", k), 64'(bc), 64'(vecs[k].expBusy));
            check($sformatf("vec%0d_done", k), 64'(dc), 64'(vecs[k].expDone));
            if (vecs[k].expDone == 1)
                check($sformatf("vec%0d_doneAt", k), 64'(dIdx), 64'(lastB + 1));
            hiM = vecs[k].expHi;
            loM = vecs[k].expLo;
            checkRegs($sformatf("vec%0d", k));
        end

        // Start while busy must be ignored: mtlo issued one cycle into a mult.
        bc = 0;
        start = 1'b1; op = 4'd1; inA = 32'd3; inB = 32'd4;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (busy) bc++;
            step();
            if (i == 0) begin start = 1'b1; op = 4'd6; inA = 32'hDEAD; end
            else begin start = 1'b0; op = 4'd0; end
        end
        check("swb_busy", 64'(bc), 64'd6);
        hiM = 32'd0; loM = 32'd12;
        checkRegs("swb");

        // Flush on the 4th busy cycle of a div, with a mult start in the same cycle.
        start = 1'b1; op = 4'd3; inA = 32'd100; inB = 32'd7;
        #1;
        check("fl_issue", {63'b0, busy}, 64'd1);
        step();
        start = 1'b0; op = 4'd0;
        step();
        step();
        flush = 1'b1; start = 1'b1; op = 4'd1; inA = 32'd3; inB = 32'd3;
        #1;
        check("fl_cyc4", {63'b0, busy}, 64'd1);
        step();
        flush = 1'b0; start = 1'b0; op = 4'd0;
        #1;
        check("fl_busy", {63'b0, busy}, 64'd0);
        check("fl_done", {63'b0, done}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy || done) cnt++;
            step();
        end
        check("fl_quiet", 64'(cnt), 64'd0);
        checkRegs("fl");

        // Asynchronous reset in the middle of a mult.
        runOp(4'd5, 32'h11111111, 32'd0, bc, dc, dIdx, lastB);
        runOp(4'd6, 32'h22222222, 32'd0, bc, dc, dIdx, lastB);
        start = 1'b1; op = 4'd1; inA = 32'd3; inB = 32'd5;
        step();
        start = 1'b0; op = 4'd0;
        step();
        reset = 1'b0;
        #1;
        check("ar_busy", {63'b0, busy}, 64'd0);
        check("ar_done", {63'b0, done}, 64'd0);
        hiM = '0; loM = '0;
        checkRegs("ar");
        step();
        reset = 1'b1;
        step();
        check("ar_post_busy", {63'b0, busy}, 64'd0);
        runOp(4'd6, 32'hA5A5A5A5, 32'd0, bc, dc, dIdx, lastB);
        loM = 32'hA5A5A5A5;
        check("ar_mt_done", 64'(dc), 64'd0);
        checkRegs("ar_mt");

        // Randomized ops against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            ro = 4'($urandom_range(0, 8));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            model(ro, ra, rb, eb, ed);
            runOp(ro, ra, rb, bc, dc, dIdx, lastB);
            check($sformatf("rnd%0d_op%0d_busy", n, ro), 64'(bc), 64'(eb));
            check($sformatf("rnd%0d_op%0d_done", n, ro), 64'(dc), 64'(ed));
            if (ed == 1)
                check($sformatf("rnd%0d_doneAt", n), 64'(dIdx), 64'(lastB + 1));
            checkRegs($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
